// File: rtl/eq_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed
// three-band stereo equalizer.
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BAND,
    MIX,
    DONE
  } eq_state_e;

  localparam int FRAC_BITS = 14;
  localparam int TAPS      = 5;
  localparam int BANDS     = 3;

  localparam logic [4:0] GAIN_BASE = 5'd15;

  function automatic logic signed [15:0] sat16(
    input logic signed [63:0] v
  );
    if (v > 64'sd32767)
      return 16'sh7fff;
    else if (v < -64'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/eq_mac.sv
// Shared signed MAC: registered operand, product accumulated the
// cycle after the operand loads, truncating saturated readout.
module eq_mac #(
  parameter int FRAC_BITS = eq_pkg::FRAC_BITS,
  parameter int ACC_W     = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_load,
  input  logic signed [15:0] op_in,
  input  logic signed [15:0] coef,
  input  logic               acc_clr,
  output logic signed [15:0] result
);
  import eq_pkg::*;

  logic signed [15:0]      op_q;
  logic                    mul_en;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      wide;

  // ROM data for the loaded operand arrives one cycle later
  assign prod    = mul_en ? 32'(coef) * 32'(op_q) : '0;
  assign sum     = acc + {{(ACC_W-32){prod[31]}}, prod};
  assign shifted = sum >>> FRAC_BITS;
  assign wide    = {{(64-ACC_W){shifted[ACC_W-1]}}, shifted};
  assign result  = sat16(wide);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      mul_en <= 1'b0;
      acc    <= '0;
    end else begin
      mul_en <= op_load;
      if (op_load)
        op_q <= op_in;
      if (acc_clr)
        acc <= '0;
      else
        acc <= sum;
    end
  end

endmodule

// File: rtl/eq_mac_scheduler.sv
// Sequences one MAC through three biquads and a gain mix per
// I2S word, with separate left/right filter histories.
module eq_mac_scheduler #(
  parameter int FRAC_BITS = eq_pkg::FRAC_BITS,
  parameter int ACC_W     = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l_r_clk,
  input  logic signed [15:0] sample_in,
  output logic [4:0]         coef_addr,
  input  logic signed [15:0] coef_data,
  output logic signed [15:0] sample_out,
  output logic               out_valid,
  output logic               out_chan,
  output logic               busy,
  output logic               overrun
);
  import eq_pkg::*;

  localparam logic [2:0] WB_TAP  = 3'(TAPS);
  localparam logic [2:0] LD_LAST = 3'(TAPS - 1);
  localparam logic [1:0] B_LAST  = 2'(BANDS - 1);

  eq_state_e state;
  logic [2:0] tap;
  logic [1:0] band;
  logic       ch;
  logic [2:0] lr_sync;
  logic       lr_edge;

  logic signed [15:0] x;
  logic signed [15:0] x1 [2];
  logic signed [15:0] x2 [2];
  logic signed [15:0] y1 [3][2];
  logic signed [15:0] y2 [3][2];

  logic               op_load;
  logic               acc_clr;
  logic signed [15:0] op_mux;
  logic signed [15:0] result;

  assign lr_edge = lr_sync[1] ^ lr_sync[2];
  assign busy    = (state != IDLE);

  assign op_load = (state == BAND && tap < WB_TAP)
                || (state == MIX && tap < 3'd3);
  assign acc_clr = (state == BAND && tap == WB_TAP)
                || (state == MIX && tap == 3'd3);

  always_comb begin
    op_mux = '0;
    unique case (1'b1)
      state == MIX:
        if (tap < 3'd3)
          op_mux = y1[tap[1:0]][ch];
      state == BAND:
        case (tap)
          3'd0:    op_mux = x;
          3'd1:    op_mux = x1[ch];
          3'd2:    op_mux = x2[ch];
          3'd3:    op_mux = y1[band][ch];
          3'd4:    op_mux = y2[band][ch];
          default: op_mux = '0;
        endcase
      default: op_mux = '0;
    endcase
  end

  eq_mac #(
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .op_load (op_load),
    .op_in   (op_mux),
    .coef    (coef_data),
    .acc_clr (acc_clr),
    .result  (result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lr_sync    <= '0;
      state      <= IDLE;
      tap        <= '0;
      band       <= '0;
      ch         <= 1'b0;
      x          <= '0;
      coef_addr  <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      out_chan   <= 1'b0;
      overrun    <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        x1[c] <= '0;
        x2[c] <= '0;
        for (int b = 0; b < 3; b++) begin
          y1[b][c] <= '0;
          y2[b][c] <= '0;
        end
      end
    end else begin
      lr_sync   <= {lr_sync[1:0], l_r_clk};
      out_valid <= 1'b0;
      // edges during a running schedule are dropped
      if (lr_edge && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (lr_edge) begin
            x         <= sample_in;
            ch        <= lr_sync[1];
            band      <= '0;
            tap       <= '0;
            coef_addr <= '0;
            state     <= BAND;
          end
        end
        BAND: begin
          if (tap == WB_TAP) begin
            y2[band][ch] <= y1[band][ch];
            y1[band][ch] <= result;
            tap          <= '0;
            if (band == B_LAST) begin
              x2[ch]    <= x1[ch];
              x1[ch]    <= x;
              band      <= '0;
              coef_addr <= GAIN_BASE;
              state     <= MIX;
            end else begin
              band      <= band + 2'd1;
              coef_addr <= coef_addr + 5'd1;
            end
          end else begin
            tap <= tap + 3'd1;
            if (tap != LD_LAST)
              coef_addr <= coef_addr + 5'd1;
          end
        end
        MIX: begin
          if (tap == 3'd3) begin
            sample_out <= result;
            out_chan   <= ch;
            out_valid  <= 1'b1;
            tap        <= '0;
            state      <= DONE;
          end else begin
            tap <= tap + 3'd1;
            if (tap != 3'd2)
              coef_addr <= coef_addr + 5'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_mac_scheduler.sv
// Bench for eq_mac_scheduler: sample-level biquad model with a
// per-cycle timeline, directed cases and randomized traffic.
module tb_eq_mac_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               l_r_clk;
  logic signed [15:0] sample_in;
  logic [4:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic signed [15:0] sample_out;
  logic               out_valid;
  logic               out_chan;
  logic               busy;
  logic               overrun;

  logic signed [15:0] rom [32];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int e;
    bit chan;
    int smp;
  } ev_t;

  ev_t evq [$];
  ev_t ev_c;
  int  got [$];
  int  gotch [$];

  int  mx1 [2];
  int  mx2 [2];
  int  my1 [3][2];
  int  my2 [3][2];
  bit  run;
  int  elast;
  int  pend_val;
  bit  pend_ch;
  int  exp_out;
  bit  exp_ch;
  int  addr_hold;
  int  ov_from;

  eq_mac_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .l_r_clk    (l_r_clk),
    .sample_in  (sample_in),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .out_chan   (out_chan),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) coef_data <= rom[coef_addr];

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                 nm, cyc, act, exp);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic longint cf(input int a);
    return longint'(rom[a]);
  endfunction

  // One stereo sample through three biquads and the gain mix
  function automatic int run_model(input bit c, input int xv);
    longint s;
    longint m;
    int     y;
    m = 0;
    for (int b = 0; b < 3; b++) begin
      s = cf(b*5) * xv + cf(b*5+1) * mx1[c]
        + cf(b*5+2) * mx2[c] + cf(b*5+3) * my1[b][c]
        + cf(b*5+4) * my2[b][c];
      y = sat(s >>> 14);
      my2[b][c] = my1[b][c];
      my1[b][c] = y;
      m += cf(15+b) * y;
    end
    mx2[c] = mx1[c];
    mx1[c] = xv;
    return sat(m >>> 14);
  endfunction

  // coef_addr expected d cycles after the accepted edge
  function automatic int addr_at(input int d);
    if (d <= 5)  return d - 1;
    if (d == 6)  return 4;
    if (d <= 11) return d - 2;
    if (d == 12) return 9;
    if (d <= 17) return d - 3;
    if (d == 18) return 14;
    if (d <= 21) return d - 4;
    return 17;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < 2; c++) begin
      mx1[c] = 0;
      mx2[c] = 0;
      for (int b = 0; b < 3; b++) begin
        my1[b][c] = 0;
        my2[b][c] = 0;
      end
    end
    run       = 1'b0;
    elast     = 0;
    pend_val  = 0;
    pend_ch   = 1'b0;
    exp_out   = 0;
    exp_ch    = 1'b0;
    addr_hold = 0;
    ov_from   = 32'h7fffffff;
    evq.delete();
  endfunction

  always @(negedge clk) begin
    bit win;
    if (reset) begin
      model_clear();
    end else begin
      while (evq.size() > 0 && evq[0].e <= cyc) begin
        ev_c = evq.pop_front();
        if (run && cyc <= elast + 23) begin
          if (ov_from > cyc + 1)
            ov_from = cyc + 1;
        end else begin
          run      = 1'b1;
          elast    = cyc;
          pend_val = run_model(ev_c.chan, ev_c.smp);
          pend_ch  = ev_c.chan;
        end
      end
      if (run && cyc > elast && cyc <= elast + 23)
        addr_hold = addr_at(cyc - elast);
      if (run && cyc == elast + 23) begin
        exp_out = pend_val;
        exp_ch  = pend_ch;
      end
    end
    win = !reset && run && cyc > elast && cyc <= elast + 23;
    chk("busy", int'(busy), int'(win));
    chk("out_valid", int'(out_valid),
        int'(!reset && run && cyc == elast + 23));
    chk("sample_out", int'(sample_out), exp_out);
    chk("out_chan", int'(out_chan), int'(exp_ch));
    chk("coef_addr", int'(coef_addr), addr_hold);
    chk("overrun", int'(overrun),
        int'(!reset && cyc >= ov_from));
  end

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got.push_back(int'(sample_out));
      gotch.push_back(int'(out_chan));
    end
  end

  function automatic int got_v(input int i);
    return (i < got.size()) ? got[i] : 99999;
  endfunction

  function automatic int got_c(input int i);
    return (i < gotch.size()) ? gotch[i] : 9;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] s);
    sample_in = s;
    l_r_clk   = ~l_r_clk;
    evq.push_back('{e: cyc + 2, chan: l_r_clk,
                    smp: int'(s)});
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    l_r_clk   = 1'b0;
    sample_in = '0;
    tick(3);
    reset = 1'b0;
    tick(3);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++)
      rom[i] = '0;
  endtask

  task automatic impulse_seq(input string tag);
    got.delete();
    gotch.delete();
    send(16'sd0);    tick(30);
    send(16'sd1000); tick(30);
    send(16'sd0);    tick(30);
    send(16'sd0);    tick(30);
    chk({tag, "_n"}, got.size(), 4);
    chk({tag, "_y1"}, got_v(1), 1000);
    chk({tag, "_c1"}, got_c(1), 0);
    chk({tag, "_y3"}, got_v(3), 0);
    chk({tag, "_c3"}, got_c(3), 0);
  endtask

  initial begin
    reset     = 1'b1;
    l_r_clk   = 1'b0;
    sample_in = '0;
    clear_rom();
    tick(3);
    chk("rst_addr", int'(coef_addr), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    tick(3);

    // impulse through the low band
    clear_rom();
    rom[0]  = 16'sd16384;
    rom[15] = 16'sd16384;
    do_reset();
    impulse_seq("imp");

    // one-sample delay, per-channel history
    clear_rom();
    rom[1]  = 16'sd16384;
    rom[15] = 16'sd16384;
    do_reset();
    got.delete();
    gotch.delete();
    send(16'sd0);    tick(30);
    send(16'sd8000); tick(30);
    send(16'sd0);    tick(30);
    send(16'sd0);    tick(30);
    send(16'sd0);    tick(30);
    chk("dly_n", got.size(), 5);
    chk("dly_y1", got_v(1), 0);
    chk("dly_y2", got_v(2), 0);
    chk("dly_y3", got_v(3), 8000);
    chk("dly_c3", got_c(3), 0);
    chk("dly_y4", got_v(4), 0);

    // saturation both directions
    clear_rom();
    rom[0]  = 16'sh7fff;
    rom[15] = 16'sd16384;
    do_reset();
    got.delete();
    gotch.delete();
    send(16'sd30000);  tick(30);
    send(-16'sd30000); tick(30);
    chk("sat_hi", got_v(0), 32767);
    chk("sat_lo", got_v(1), -32768);

    // overrun: second edge ten cycles into the schedule
    clear_rom();
    rom[0]  = 16'sd16384;
    rom[15] = 16'sd16384;
    do_reset();
    got.delete();
    gotch.delete();
    send(16'sd500);  tick(10);
    send(16'sd777);  tick(40);
    chk("ovr_n", got.size(), 1);
    chk("ovr_y", got_v(0), 500);
    chk("ovr_flag", int'(overrun), 1);
    send(16'sd0);    tick(30);
    chk("ovr_n2", got.size(), 2);
    chk("ovr_hold", int'(overrun), 1);
    do_reset();
    chk("ovr_clr", int'(overrun), 0);

    // reset in the middle of a schedule
    got.delete();
    gotch.delete();
    send(16'sd1000); tick(14);
    do_reset();
    tick(30);
    chk("mrst_n", got.size(), 0);
    chk("mrst_out", int'(sample_out), 0);
    impulse_seq("rerun");

    // randomized coefficients, samples and edge spacing
    clear_rom();
    for (int i = 0; i < 18; i++)
      rom[i] = $signed(16'($urandom)) >>> $urandom_range(0, 3);
    do_reset();
    for (int n = 0; n < 200; n++) begin
      send(16'($urandom));
      if (n == 100) begin
        tick($urandom_range(1, 30));
        do_reset();
      end else if ($urandom_range(0, 7) == 0) begin
        tick($urandom_range(3, 24));
      end else begin
        tick($urandom_range(25, 40));
      end
    end
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
